// File: rtl/pb_gesture_decoder.sv
// Turns debounced push-button events into single/double/long-press and auto-repeat pulses.
// Optional PB_AUTOREPEAT_EN: when defined, LONG emits o_repeat every REPEAT_CYCLES.
module pb_gesture_decoder #(
    parameter int LONG_CYCLES   = 20000000,
    parameter int GAP_CYCLES    = 5000000,
    parameter int REPEAT_CYCLES = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pb_status,
    input  logic i_pb_press,
    input  logic i_pb_release,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_busy
);

    localparam int MAX_LG    = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_C     = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int CNT_WIDTH = $clog2(MAX_C) + 1;

    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
`ifdef PB_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HELD   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_SECOND = 3'd3;
    localparam logic [2:0] S_LONG   = 3'd4;

    logic [2:0]           state, state_nx;
    logic [CNT_WIDTH-1:0] timer, timer_nx;
    logic                 low_seen, low_nx;
    logic                 guard_lo;
    logic                 single_nx, double_nx, long_nx, repeat_nx;

    // Level low with no release pulse: a candidate missed release.
    assign guard_lo = !i_pb_status && !i_pb_release;

    always_comb begin
        state_nx  = state;
        timer_nx  = timer + 1'b1;
        low_nx    = 1'b0;
        single_nx = 1'b0;
        double_nx = 1'b0;
        long_nx   = 1'b0;
        repeat_nx = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nx = '0;
                if (i_pb_press) state_nx = S_HELD;
            end
            S_HELD: begin
                low_nx = guard_lo;
                if (i_pb_release) begin
                    state_nx = S_GAP;
                end else if (low_seen && guard_lo) begin
                    state_nx = S_IDLE;
                end else if (timer == LONG_LAST) begin
                    state_nx = S_LONG;
                    long_nx  = 1'b1;
                end
            end
            S_GAP: begin
                if (i_pb_press) begin
                    state_nx  = S_SECOND;
                    double_nx = 1'b1;
                end else if (timer == GAP_LAST) begin
                    state_nx  = S_IDLE;
                    single_nx = 1'b1;
                end
            end
            S_SECOND: begin
                timer_nx = '0;
                low_nx   = guard_lo;
                if (i_pb_release || (low_seen && guard_lo)) state_nx = S_IDLE;
            end
            S_LONG: begin
                low_nx = guard_lo;
                if (i_pb_release || (low_seen && guard_lo)) begin
                    state_nx = S_IDLE;
                end else begin
`ifdef PB_AUTOREPEAT_EN
                    if (timer == REP_LAST) begin
                        repeat_nx = 1'b1;
                        timer_nx  = '0;
                    end
`else
                    timer_nx = '0;
`endif
                end
            end
            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase
        // Every state entry restarts the timer.
        if (state_nx != state) timer_nx = '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            low_seen <= 1'b0;
            o_single <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
            o_repeat <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            low_seen <= low_nx;
            o_single <= single_nx;
            o_double <= double_nx;
            o_long   <= long_nx;
            o_repeat <= repeat_nx;
            o_busy   <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// Scoreboard bench for pb_gesture_decoder with LONG=20, GAP=10, REPEAT=5.
module tb_pb_gesture_decoder;

    localparam int LONG_C = 20;
    localparam int GAP_C  = 10;
    localparam int REP_C  = 5;

    localparam logic [3:0] P_SINGLE = 4'b1000;
    localparam logic [3:0] P_DOUBLE = 4'b0100;
    localparam logic [3:0] P_LONG   = 4'b0010;
    localparam logic [3:0] P_REPEAT = 4'b0001;

    logic clk = 1'b0;
    logic rst_n;
    logic pb_status, pb_press, pb_release;
    logic o_single, o_double, o_long, o_repeat, o_busy;

    int unsigned cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    // Each entry: {expected cycle, pulse code single/double/long/repeat}.
    logic [35:0] exp_q[$];

    pb_gesture_decoder #(
        .LONG_CYCLES  (LONG_C),
        .GAP_CYCLES   (GAP_C),
        .REPEAT_CYCLES(REP_C)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pb_status (pb_status),
        .i_pb_press  (pb_press),
        .i_pb_release(pb_release),
        .o_single    (o_single),
        .o_double    (o_double),
        .o_long      (o_long),
        .o_repeat    (o_repeat),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [3:0]  obs;
        logic [35:0] e;
        obs = {o_single, o_double, o_long, o_repeat};
        if (obs != 4'b0000) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if ({cyc, obs} !== e)
                    $display("FAIL pulse cyc=%0d got=%b required cyc=%0d code=%b",
                             cyc, obs, e[35:4], e[3:0]);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick(input logic st, input logic pr, input logic rl);
        pb_status  = st;
        pb_press   = pr;
        pb_release = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic st);
        for (int i = 0; i < n; i++) tick(st, 1'b0, 1'b0);
    endtask

    task automatic expect_pulse(input int unsigned at, input logic [3:0] code);
        exp_q.push_back({at, code});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        hold(3, 1'b0);
        total_cnt++;
        if ({o_single, o_double, o_long, o_repeat, o_busy} !== 5'b0)
            $display("FAIL reset_outputs got=%b required=00000",
                     {o_single, o_double, o_long, o_repeat, o_busy});
        else pass_cnt++;
        rst_n = 1'b1;
        hold(2, 1'b0);
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", o_busy);
        else pass_cnt++;
    endtask

    task automatic test_single;
        int unsigned t0;
        t0 = cyc;
        expect_pulse(t0 + 16, P_SINGLE);
        tick(1'b1, 1'b1, 1'b0);
        hold(4, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        hold(9, 1'b0);
        total_cnt++;
        if (o_busy !== 1'b1) $display("FAIL single_busy_gap got=%b required=1", o_busy);
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL single_busy_fall got=%b required=0", o_busy);
        else pass_cnt++;
        hold(4, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL single_missing got=%0d required=0 pending", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_double;
        int unsigned t0;
        t0 = cyc;
        expect_pulse(t0 + 9, P_DOUBLE);
        tick(1'b1, 1'b1, 1'b0);
        hold(2, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        hold(4, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        hold(3, 1'b1);
        total_cnt++;
        if (o_busy !== 1'b1) $display("FAIL double_busy_second got=%b required=1", o_busy);
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL double_busy_fall got=%b required=0", o_busy);
        else pass_cnt++;
        hold(15, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL double_missing got=%0d required=0 pending", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_long;
        int unsigned t0;
        t0 = cyc;
        expect_pulse(t0 + LONG_C + 1, P_LONG);
`ifdef PB_AUTOREPEAT_EN
        for (int k = 1; k <= 4; k++) expect_pulse(t0 + LONG_C + 1 + k * REP_C, P_REPEAT);
`endif
        tick(1'b1, 1'b1, 1'b0);
        hold(41, 1'b1);
        tick(1'b1, 1'b1, 1'b0);  // stray press while long-held
        tick(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL long_busy_fall got=%b required=0", o_busy);
        else pass_cnt++;
        hold(6, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL long_missing got=%0d required=0 pending", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_boundaries;
        int unsigned t0;
        // Release on the last HELD cycle, second press on the last GAP cycle.
        t0 = cyc;
        expect_pulse(t0 + 31, P_DOUBLE);
        tick(1'b1, 1'b1, 1'b0);
        hold(19, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        hold(9, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        hold(2, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL bound_busy got=%b required=0", o_busy);
        else pass_cnt++;
        hold(12, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL bound_gap_missing got=%0d required=0 pending", exp_q.size());
        else pass_cnt++;
        // Release on the repeat cycle suppresses the repeat pulse.
        t0 = cyc;
        expect_pulse(t0 + LONG_C + 1, P_LONG);
        tick(1'b1, 1'b1, 1'b0);
        hold(24, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        hold(8, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL bound_rep_missing got=%0d required=0 pending", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int unsigned t0;
        tick(1'b1, 1'b1, 1'b0);
        hold(11, 1'b1);
        rst_n = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        total_cnt++;
        if ({o_single, o_double, o_long, o_repeat, o_busy} !== 5'b0)
            $display("FAIL midreset_outputs got=%b required=00000",
                     {o_single, o_double, o_long, o_repeat, o_busy});
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b1);
        hold(25, 1'b0);
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL midreset_busy got=%b required=0", o_busy);
        else pass_cnt++;
        t0 = cyc;
        expect_pulse(t0 + 13, P_SINGLE);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        hold(14, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL midreset_fresh got=%0d required=0 pending", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_missed_release;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (o_busy !== 1'b1) $display("FAIL missed_one_low got=%b required=1", o_busy);
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL missed_guard got=%b required=0", o_busy);
        else pass_cnt++;
        hold(30, 1'b0);
        tick(1'b0, 1'b0, 1'b1);  // stray release in IDLE
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL stray_release_busy got=%b required=0", o_busy);
        else pass_cnt++;
        hold(15, 1'b0);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL missed_pending got=%0d required=0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b0;
        pb_status  = 1'b0;
        pb_press   = 1'b0;
        pb_release = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_double();
        test_long();
        test_boundaries();
        test_reset_mid();
        test_missed_release();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
